// File: rtl/wb_master_seq.sv
// -----------------------------------------------------------------------------
// wb_master_seq
//
// Wishbone classic master sequencer. Accepts single or burst commands on a
// valid/ready interface, runs one classic Wishbone cycle per beat, returns read
// data per beat and reports completion/abort per command.
//
// Parameters
//   AW       address width
//   DW       data width (multiple of 8)
//   SW       byte-select width, derived as DW/8
//   LENW     burst length field width (burst = cmd_len+1 beats, up to 2**LENW)
//   TIMEOUT  max cycles a strobe waits for ack_i/err_i, 0 disables
//   GAP_CYC  extra idle cycles (cyc_o high, stb_o low) between beats
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_we, cmd_addr, cmd_sel,
//                         cmd_len (beats-1), cmd_incr (address += SW per beat)
//   wdat_valid/wdat_ready write beat handshake, wdat = beat data
//   rdat_valid, rdat      read beat return, one-cycle pulse, no backpressure
//   done_o, err_o         end-of-command pulse, err_o qualifies an abort
//   beat_cnt_o            beats completed in the current or last command
//   cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, dat_i, ack_i, err_i
//                         Wishbone classic master port
// -----------------------------------------------------------------------------
module wb_master_seq #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int LENW    = 4,
  parameter int TIMEOUT = 255,
  parameter int GAP_CYC = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // command channel
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [SW-1:0]   cmd_sel,
  input  logic [LENW-1:0] cmd_len,
  input  logic            cmd_incr,
  // write data channel
  input  logic            wdat_valid,
  output logic            wdat_ready,
  input  logic [DW-1:0]   wdat,
  // read data return
  output logic            rdat_valid,
  output logic [DW-1:0]   rdat,
  // status
  output logic            done_o,
  output logic            err_o,
  output logic [LENW:0]   beat_cnt_o,
  // Wishbone master
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [AW-1:0]   adr_o,
  output logic [SW-1:0]   sel_o,
  output logic [DW-1:0]   dat_o,
  input  logic [DW-1:0]   dat_i,
  input  logic            ack_i,
  input  logic            err_i
);

  // Counter widths; kept at least one bit so a disabled feature still elaborates.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_BEAT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nx;

  // Latched command and per-command bookkeeping
  logic            wr_mode;
  logic            incr_mode;
  logic [LENW-1:0] burst_len;
  logic [AW-1:0]   adr;
  logic [SW-1:0]   sel;
  logic [DW-1:0]   dat;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic [LENW:0]   beats;
  logic [TW-1:0]   tmo_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            abort;
  // Keeps cmd_ready low for the first cycle after reset is released.
  logic            rst_hold;

  logic cmd_hs;
  logic last_beat;
  logic tmo_hit;
  logic gap_end;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign last_beat = (beats == {1'b0, burst_len});
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign gap_end   = (gap_cnt == GW'(GAP_CYC - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      rst_hold <= 1'b1;
    end else begin
      state    <= state_nx;
      rst_hold <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_hs) state_nx = S_LOAD;
      end
      S_LOAD: begin
        // Reads go straight on; writes wait here for a data beat.
        if (!wr_mode || wdat_valid) state_nx = S_BEAT;
      end
      S_BEAT: begin
        // err_i takes priority over a simultaneous ack_i; an ack in the last
        // timeout cycle still completes the beat.
        if (err_i) begin
          state_nx = S_DONE;
        end else if (ack_i) begin
          if (last_beat)        state_nx = S_DONE;
          else if (GAP_CYC > 0) state_nx = S_GAP;
          else                  state_nx = S_LOAD;
        end else if (tmo_hit) begin
          state_nx = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_end) state_nx = S_LOAD;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready  = 1'b0;
    wdat_ready = 1'b0;
    cyc_o      = 1'b0;
    stb_o      = 1'b0;
    we_o       = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = !rst_i && !rst_hold;
      end
      S_LOAD: begin
        cyc_o      = 1'b1;
        we_o       = wr_mode;
        wdat_ready = wr_mode;
      end
      S_BEAT: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = wr_mode;
      end
      S_GAP: begin
        cyc_o = 1'b1;
        we_o  = wr_mode;
      end
      S_DONE: begin
        done_o = 1'b1;
        err_o  = abort;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign adr_o      = adr;
  assign sel_o      = sel;
  assign dat_o      = dat;
  assign rdat       = rdata;
  assign rdat_valid = rvalid;
  assign beat_cnt_o = beats;

  // ---------------------------------------------------------------------------
  // Command latch, beat datapath and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_mode   <= 1'b0;
      incr_mode <= 1'b0;
      burst_len <= '0;
      adr       <= '0;
      sel       <= '0;
      dat       <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      beats     <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      abort     <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            wr_mode   <= cmd_we;
            incr_mode <= cmd_incr;
            burst_len <= cmd_len;
            adr       <= cmd_addr;
            sel       <= cmd_sel;
            beats     <= '0;
            tmo_cnt   <= '0;
            abort     <= 1'b0;
          end
        end
        S_LOAD: begin
          // Every beat passes through LOAD, so the timeout restarts per beat.
          tmo_cnt <= '0;
          gap_cnt <= '0;
          if (wr_mode && wdat_valid) dat <= wdat;
        end
        S_BEAT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (err_i) begin
            abort <= 1'b1;
          end else if (ack_i) begin
            beats <= beats + (LENW + 1)'(1);
            if (!wr_mode) begin
              rdata  <= dat_i;
              rvalid <= 1'b1;
            end
            // Address wraps silently modulo 2**AW.
            if (!last_beat && incr_mode) adr <= adr + AW'(SW);
          end else if (tmo_hit) begin
            abort <= 1'b1;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
        end
        default: begin
          gap_cnt <= gap_cnt;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
- Parametrised Wishbone master sequencer for the WB-to-AHB bridge testbench and for on-chip self-test.
- Takes commands (single or burst, read or write) on a valid/ready interface and drives Wishbone classic cycles on the bridge's WB slave port.
- Returns read data per beat and reports completion and errors per command.
- Drives defined values at all times, never X, including in reset.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- SW, DW/8, byte-select width; derived, do not override.
- LENW, 4, burst length field width; maximum burst is 2**LENW beats.
- TIMEOUT, 255, maximum cycles stb_o waits for ack_i/err_i; 0 disables the timeout.
- GAP_CYC, 0, extra idle cycles (cyc_o high, stb_o low) inserted between beats.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  AW  start address
- cmd_sel  in  SW  byte selects, applied to every beat
- cmd_len  in  LENW  beats-1
- cmd_incr  in  1  1 = address += SW per beat, 0 = fixed address
- wdat_valid  in  1  write data offered
- wdat_ready  out  1  write data consumed when wdat_valid && wdat_ready
- wdat  in  DW  write beat data
- rdat_valid  out  1  read beat valid; one-cycle pulse, no backpressure
- rdat  out  DW  read beat data
- done_o  out  1  one-cycle pulse at command end
- err_o  out  1  qualifies done_o: command aborted
- beat_cnt_o  out  LENW+1  beats completed in the current or last command
- cyc_o, stb_o, we_o  out  1  Wishbone controls
- adr_o  out  AW  Wishbone address
- sel_o  out  SW  Wishbone byte selects
- dat_o  out  DW  Wishbone write data
- dat_i  in  DW  Wishbone read data
- ack_i  in  1  Wishbone acknowledge
- err_i  in  1  Wishbone error

Behaviour:

Reset:
- Synchronous, active-high; rst_i is sampled on rising clk_i.
- While rst_i is high and one cycle after, all outputs are 0, including adr_o, dat_o, sel_o and rdat.
- State returns to IDLE.
- Reset mid-command aborts immediately: cyc_o/stb_o are 0 on the first edge; no done_o is produced.

State machine:
- IDLE:
  - cmd_ready=1, cyc_o=0, stb_o=0.
  - On handshake, latch we, addr, sel, len, incr; clear beat_cnt_o and the timeout counter; go to LOAD.
- LOAD:
  - cmd_ready=0, cyc_o=1, stb_o=0.
  - Read: go to BEAT next cycle.
  - Write: wdat_ready=1. On wdat handshake, register wdat to dat_o and go to BEAT; otherwise stay, holding cyc_o=1.
- BEAT:
  - cyc_o=stb_o=1; adr_o, sel_o, we_o, dat_o held stable; timeout counter increments each cycle.
  - ack_i=1 and err_i=0:
    - beat completes; beat_cnt_o+1.
    - Read: rdat<=dat_i and rdat_valid=1 on the next cycle.
    - If this was the last beat, go to DONE. Otherwise advance the address if incr (modulo 2**AW, silent wrap), then go to GAP if GAP_CYC>0, else LOAD.
  - err_i=1 (wins over a simultaneous ack_i): abort to DONE with the error flag set; the beat is not counted; no rdat_valid.
  - Timeout counter reaches TIMEOUT (TIMEOUT≠0): abort to DONE with the error flag set.
- GAP:
  - cyc_o=1, stb_o=0 for exactly GAP_CYC cycles, then LOAD.
- DONE:
  - cyc_o=stb_o=0, done_o=1 for one cycle, err_o=error flag; then IDLE.
  - cmd_ready rises the cycle after DONE.

Timing and protocol rules:
- Read latency: cmd handshake at edge N → stb_o high from N+2. Ack sampled at edge M → rdat_valid high in cycle M+1.
- stb_o always drops for at least one cycle between beats (classic cycles, no pipelining).
- ack_i and err_i are ignored while stb_o=0.
- The timeout counter resets at every beat start.
- we_o=0 for reads; dat_o is held at its last value for reads.
- Single beat: cmd_len=0. Maximum burst: cmd_len=all-ones.

Test Plan:
- Single write: addr 0x100, data 0xDEADBEEF, sel 0xF, ack after 2 wait cycles → one stb_o window of 3 cycles with dat_o=0xDEADBEEF, done_o=1, err_o=0, beat_cnt_o=1.
- Incrementing read burst: cmd_len=3 at 0x200, slave returns 0x11,0x22,0x33,0x44 → adr_o sequence 0x200/0x204/0x208/0x20C; four rdat_valid pulses in order; beat_cnt_o=4; done_o once.
- Fixed-address write burst: len 2, GAP_CYC=2, wdat_valid held low 3 cycles before beat 2 → adr_o constant; cyc_o stays high throughout; stb_o low ≥2 cycles between beats; beat 2 waits in LOAD.
- Error/timeout:
  - err_i with ack_i on beat 2 of 4 → done_o with err_o=1, beat_cnt_o=1, cyc_o low next cycle.
  - No ack, TIMEOUT=8 → abort after 8 stb_o cycles with err_o=1.
- Address wrap: incr read at 0xFFFFFFFC, len 1 → second adr_o=0x00000000.
- Reset mid-burst: assert rst_i during BEAT → all outputs 0 on the next edge, no done_o; a new command after reset completes normally.
